sync_fifo_flex: RTL and testbench

Single-clock parametrised FIFO; the single-domain successor of the team's async FIFO.
Adds programmable almost-full/almost-empty thresholds, an occupancy count and a selectable read mode (standard or first-word-fall-through).
Used wherever producer and consumer share one clock: stream buffering, rate smoothing and packet staging in front of the async crossing.

---
 rtl/sync_fifo_flex.sv | 116 +++++++++++
 tb/tb_sync_fifo_flex.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with occupancy count, almost-full/almost-empty flags and standard or FWFT read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky o_overflow/o_underflow flags cleared by i_err_clr.
module sync_fifo_flex #(
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_DEPTH    = 128,
   parameter int AFULL_THRESH  = DATA_DEPTH - 8,
   parameter int AEMPTY_THRESH = 8,
   parameter int FWFT          = 0
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wren,
   input  logic [DATA_WIDTH-1:0]         i_wdata,
   input  logic                          i_rden,
   output logic [DATA_WIDTH-1:0]         o_rdata,
   output logic                          o_full,
   output logic                          o_empty,
   output logic                          o_afull,
   output logic                          o_aempty,
   output logic [$clog2(DATA_DEPTH):0]   o_count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
   ,
   input  logic                          i_err_clr,
   output logic                          o_overflow,
   output logic                          o_underflow
`endif
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DATA_DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   if ((DATA_DEPTH < 4) || ((DATA_DEPTH & (DATA_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_flex: DATA_DEPTH must be a power of two >= 4");
   end
   if ((AFULL_THRESH < 1) || (AFULL_THRESH > DATA_DEPTH)) begin : g_bad_afull
      $error("sync_fifo_flex: AFULL_THRESH out of range 1..DATA_DEPTH");
   end
   if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DATA_DEPTH - 1)) begin : g_bad_aempty
      $error("sync_fifo_flex: AEMPTY_THRESH out of range 0..DATA_DEPTH-1");
   end

   logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Handshake: on a rising edge a write is taken when i_wren=1 and o_full=0, a read when
   // i_rden=1 and o_empty=0; any other request is dropped with no state change.
   assign wr_acc = i_wren & ~o_full;
   assign rd_acc = i_rden & ~o_empty;

   assign o_full   = (count_q == DEPTH_C);
   assign o_empty  = (count_q == '0);
   assign o_afull  = (count_q >= AFULL_C);
   assign o_aempty = (count_q <= AEMPTY_C);
   assign o_count  = count_q;

   // Storage has no reset so it maps onto plain RAM.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_acc, rd_acc})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is visible straight from storage; meaningless while empty.
      assign o_rdata = mem[rd_ptr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            rdata_q <= '0;
         end else if (rd_acc) begin
            rdata_q <= mem[rd_ptr];
         end
      end
      assign o_rdata = rdata_q;
   end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   // Sticky error flags; a new error in the clear cycle wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_overflow  <= (i_wren & o_full)  | (o_overflow  & ~i_err_clr);
         o_underflow <= (i_rden & o_empty) | (o_underflow & ~i_err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: drives a standard-mode and an FWFT-mode sync_fifo_flex with the same stimulus
// and compares both against a queue-based reference model of the FIFO rules.
module tb_sync_fifo_flex;

  localparam int DW     = 8;
  localparam int DEPTH  = 128;
  localparam int AFULL  = DEPTH - 8;
  localparam int AEMPTY = 8;

  logic          clk;
  logic          rst_n;
  logic          wren;
  logic [DW-1:0] wdata;
  logic          rden;
  logic [DW-1:0] s_rdata, f_rdata;
  logic          s_full, s_empty, s_afull, s_aempty;
  logic          f_full, f_empty, f_afull, f_aempty;
  logic [7:0]    s_count, f_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          err_clr;
  logic          s_ovf, s_unf, f_ovf, f_unf;
`endif

  sync_fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AFULL_THRESH(AFULL),
                   .AEMPTY_THRESH(AEMPTY), .FWFT(0)) dut_std (
    .i_clk(clk), .i_rst_n(rst_n), .i_wren(wren), .i_wdata(wdata), .i_rden(rden),
    .o_rdata(s_rdata), .o_full(s_full), .o_empty(s_empty), .o_afull(s_afull),
    .o_aempty(s_aempty), .o_count(s_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .i_err_clr(err_clr), .o_overflow(s_ovf), .o_underflow(s_unf)
`endif
  );

  sync_fifo_flex #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .AFULL_THRESH(AFULL),
                   .AEMPTY_THRESH(AEMPTY), .FWFT(1)) dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_wren(wren), .i_wdata(wdata), .i_rden(rden),
    .o_rdata(f_rdata), .o_full(f_full), .o_empty(f_empty), .o_afull(f_afull),
    .o_aempty(f_aempty), .o_count(f_count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    , .i_err_clr(err_clr), .o_overflow(f_ovf), .o_underflow(f_unf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rdata_exp;
  logic          ovf_exp;
  logic          unf_exp;
  int            n_checks;
  int            n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = exp_q.size();
    check("std_count",  32'(s_count),  32'(n));
    check("std_full",   32'(s_full),   32'(n == DEPTH));
    check("std_empty",  32'(s_empty),  32'(n == 0));
    check("std_afull",  32'(s_afull),  32'(n >= AFULL));
    check("std_aempty", 32'(s_aempty), 32'(n <= AEMPTY));
    check("std_rdata",  32'(s_rdata),  32'(rdata_exp));
    check("fwft_count", 32'(f_count),  32'(n));
    check("fwft_empty", 32'(f_empty),  32'(n == 0));
    if (n != 0) check("fwft_rdata", 32'(f_rdata), 32'(exp_q[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    check("overflow",  32'(s_ovf), 32'(ovf_exp));
    check("underflow", 32'(s_unf), 32'(unf_exp));
`endif
  endtask

  // driver: one clock cycle of stimulus, model update after the edge, check 1ns later
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
    logic was_full, was_empty, wr_ok, rd_ok;
    wren  = wr;
    wdata = wd;
    rden  = rd;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    wr_ok = wr && !was_full;
    rd_ok = rd && !was_empty;
    @(posedge clk);
    if (rd_ok) rdata_exp = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(wd);
    ovf_exp = (wr && was_full)  || (ovf_exp && !clr);
    unf_exp = (rd && was_empty) || (unf_exp && !clr);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    wren = 1'b0;
    rden = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    rdata_exp = '0;
    ovf_exp = 1'b0;
    unf_exp = 1'b0;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rdata_exp = '0;
    ovf_exp   = 1'b0;
    unf_exp   = 1'b0;
    rst_n = 1'b0;
    wren  = 1'b0;
    rden  = 1'b0;
    wdata = '0;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    err_clr = 1'b0;
`endif
    #12;
    check_outputs();
    check("fwft_full_rst", 32'(f_full), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // fill 0x00..0x7F, flags tracked every cycle
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    // writes while full are dropped (and raise overflow)
    for (int i = 0; i < 10; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
    // drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    // read while empty, hold, then clear with a fresh underflow in the same cycle
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    // simultaneous read+write while empty: only the write lands
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // single write into empty: FWFT head visible without a read, then pop
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // steady state at 64 with simultaneous traffic, pointers wrap
    for (int i = 0; i < 64; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), 1'b1, 1'b0);
    // fill to full then read+write while full: read taken, write dropped
    while (exp_q.size() < DEPTH) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset in the middle of traffic at count 50
    while (exp_q.size() > 50) step(1'b0, 8'h00, 1'b1, 1'b0);
    mid_reset();
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // randomized traffic with shifting write/read bias
    for (int i = 0; i < 1500; i++) begin
      int pw, pr;
      case ((i / 250) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      step(1'($urandom_range(0, 99) < pw), DW'($urandom),
           1'($urandom_range(0, 99) < pr), 1'($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
